// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard button path.
// Contents: arbiter FSM state enum, team enum, default debounce length,
// width of the dropped-press counter.
package placar_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned DESC_W              = 8;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETTLE,
        WAIT,
        LOCKED
    } arb_state_t;

    typedef enum logic {
        TEAM_A,
        TEAM_B
    } team_t;

endpackage

// File: rtl/debounce_botao.sv
// Conditions one raw active-low button.
// The button passes through a 2-FF synchroniser and then a stability counter.
// A one-cycle press pulse is emitted when the debounced level falls.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_btn_n     - raw asynchronous button, 0 = pressed
//   o_press     - registered one-cycle pulse on debounced press
module debounce_botao #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Synchroniser, stability counter and debounced level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_deb   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= 1'b0;
            if (r_sync[1] != r_deb) begin
                // This edge brings the count to DEBOUNCE_CYCLES: accept the new level
                if (r_cnt == CNT_LAST) begin
                    r_deb   <= r_sync[1];
                    r_cnt   <= '0;
                    r_press <= ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/arbitro_botoes.sv
// Input conditioner and arbiter between the team buttons and the
// scoreboard controller. Each debounced press latches a pending request.
// Pending requests are granted one at a time, round-robin on conflict,
// and granting is held off while busy. Game over locks the arbiter until reset.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   Ba, Bb            - raw team buttons, active-low, asynchronous
//   busy              - controller is processing a point
//   fim_jogo          - game over
//   ponto_a, ponto_b  - one-cycle grant pulses
//   pend_a, pend_b    - pending-request flags
//   descartes         - saturating dropped-press count
// Build option: ARB_DESCARTES_EN enables the descartes counter. When it is
// undefined, descartes is tied to 0.
module arbitro_botoes
    import placar_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Ba,
    input  logic              Bb,
    input  logic              busy,
    input  logic              fim_jogo,
    output logic              ponto_a,
    output logic              ponto_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic [DESC_W-1:0] descartes
);

    logic       w_press_a;
    logic       w_press_b;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    team_t      r_prio;
    team_t      w_prio_nxt;
    logic       r_ponto_a;
    logic       r_ponto_b;
    logic       w_ponto_a_nxt;
    logic       w_ponto_b_nxt;
    logic       r_pend_a;
    logic       r_pend_b;
    logic       w_pend_a_nxt;
    logic       w_pend_b_nxt;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (Ba),
        .o_press (w_press_a)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (Bb),
        .o_press (w_press_b)
    );

    // State, priority, pending flags and grant pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_prio    <= TEAM_A;
            r_ponto_a <= 1'b0;
            r_ponto_b <= 1'b0;
            r_pend_a  <= 1'b0;
            r_pend_b  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prio    <= w_prio_nxt;
            r_ponto_a <= w_ponto_a_nxt;
            r_ponto_b <= w_ponto_b_nxt;
            r_pend_a  <= w_pend_a_nxt;
            r_pend_b  <= w_pend_b_nxt;
        end
    end

    // Next state and next outputs; the grant pulse and pend clear are
    // registered on the edge entering GRANT
    always_comb begin
        w_state_nxt   = r_state;
        w_prio_nxt    = r_prio;
        w_ponto_a_nxt = 1'b0;
        w_ponto_b_nxt = 1'b0;
        w_pend_a_nxt  = r_pend_a | w_press_a;
        w_pend_b_nxt  = r_pend_b | w_press_b;

        case (r_state)
            IDLE: begin
                if (!busy && (r_pend_a || r_pend_b)) begin
                    w_state_nxt = GRANT;
                    if (r_pend_a && (!r_pend_b || (r_prio == TEAM_A))) begin
                        w_ponto_a_nxt = 1'b1;
                        w_pend_a_nxt  = 1'b0;
                        w_prio_nxt    = TEAM_B;
                    end else begin
                        w_ponto_b_nxt = 1'b1;
                        w_pend_b_nxt  = 1'b0;
                        w_prio_nxt    = TEAM_A;
                    end
                end
            end
            GRANT:  w_state_nxt = SETTLE;
            SETTLE: w_state_nxt = WAIT;
            WAIT: begin
                if (!busy) begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKED: begin
                w_pend_a_nxt = 1'b0;
                w_pend_b_nxt = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Game over overrides everything, including a grant decided this cycle
        if (fim_jogo) begin
            w_state_nxt   = LOCKED;
            w_prio_nxt    = r_prio;
            w_ponto_a_nxt = 1'b0;
            w_ponto_b_nxt = 1'b0;
            w_pend_a_nxt  = 1'b0;
            w_pend_b_nxt  = 1'b0;
        end
    end

    assign ponto_a = r_ponto_a;
    assign ponto_b = r_ponto_b;
    assign pend_a  = r_pend_a;
    assign pend_b  = r_pend_b;

`ifdef ARB_DESCARTES_EN
    logic              w_drop_a;
    logic              w_drop_b;
    logic [DESC_W:0]   w_desc_sum;
    logic [DESC_W-1:0] r_descartes;

    // A press is dropped when its request is already pending or the game is over
    assign w_drop_a   = w_press_a & (r_pend_a | (r_state == LOCKED));
    assign w_drop_b   = w_press_b & (r_pend_b | (r_state == LOCKED));
    assign w_desc_sum = {1'b0, r_descartes} + (DESC_W+1)'(w_drop_a) + (DESC_W+1)'(w_drop_b);

    // Saturating dropped-press counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_descartes <= '0;
        end else begin
            r_descartes <= w_desc_sum[DESC_W] ? {DESC_W{1'b1}} : w_desc_sum[DESC_W-1:0];
        end
    end

    assign descartes = r_descartes;
`else
    assign descartes = '0;
`endif

endmodule

// File: tb/tb_arbitro_botoes.sv
// Self-checking bench for arbitro_botoes: random press scenarios, a timing
// reference model feeding an expected-grant queue, and a monitor that checks
// every grant pulse against that queue.
module tb_arbitro_botoes;
    import placar_pkg::*;

    localparam int DEB  = 4;
    localparam int NONE = 1 << 30;
`ifdef ARB_DESCARTES_EN
    localparam bit DESC_ON = 1'b1;
`else
    localparam bit DESC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       Ba;
    logic       Bb;
    logic       busy;
    logic       fim_jogo;
    logic       ponto_a;
    logic       ponto_b;
    logic       pend_a;
    logic       pend_b;
    logic [7:0] descartes;

    arbitro_botoes #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .Ba        (Ba),
        .Bb        (Bb),
        .busy      (busy),
        .fim_jogo  (fim_jogo),
        .ponto_a   (ponto_a),
        .ponto_b   (ponto_b),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .descartes (descartes)
    );

    always #5 clk = ~clk;

    // Edge counter: at the falling edge after rising edge n, cyc == n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int team;    // 0 = A, 1 = B
        int edge_n;  // rising edge on which the pulse appears
    } grant_t;

    grant_t exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     m_prio   = 0;   // model round-robin priority, 0 = A
    int     exp_desc = 0;   // model dropped-press count

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input int team, input int edge_n);
        grant_t g;
        g.team   = team;
        g.edge_n = edge_n;
        exp_q.push_back(g);
    endtask

    // Scoreboard monitor: every pulse must match the head of the queue
    always @(negedge clk) begin : mon
        grant_t g;
        if (!reset && (ponto_a || ponto_b)) begin
            check("grant_exclusive", int'(ponto_a & ponto_b), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got a=%0d b=%0d expected none at edge %0d",
                         ponto_a, ponto_b, cyc);
            end else begin
                g = exp_q.pop_front();
                check("grant_team", ponto_b ? 1 : 0, g.team);
                check("grant_edge", cyc, g.edge_n);
            end
        end
    end

    task automatic drain_check(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Scenario kinds: 0 A press, 1 B press, 2 glitch, 3 tie, 4 offset pair,
    // 5 press under busy, 6 repeated A press while pending
    task automatic run_scn(input int kind);
        int a_en, a_st, a_len, b_en, b_st, b_len, busy_len, a2_en, a2_st;
        int pa, pb, ga, gb, t, k0, n, p2, na, nb, first, last_in;
        a_en = 0; a_st = 0; a_len = 0; b_en = 0; b_st = 0; b_len = 0;
        busy_len = 0; a2_en = 0; a2_st = 0;
        case (kind)
            0: begin a_en = 1; a_st = int'($urandom_range(0, 3)); a_len = int'($urandom_range(DEB, DEB + 6)); end
            1: begin b_en = 1; b_st = int'($urandom_range(0, 3)); b_len = int'($urandom_range(DEB, DEB + 6)); end
            2: begin
                if ($urandom_range(0, 1) == 1) begin a_en = 1; a_len = int'($urandom_range(1, DEB - 1)); end
                else begin b_en = 1; b_len = int'($urandom_range(1, DEB - 1)); end
            end
            3: begin
                a_en = 1; b_en = 1; a_st = int'($urandom_range(0, 3)); b_st = a_st;
                a_len = int'($urandom_range(DEB, DEB + 6)); b_len = int'($urandom_range(DEB, DEB + 6));
            end
            4: begin
                a_en = 1; b_en = 1; a_st = int'($urandom_range(0, 7)); b_st = int'($urandom_range(0, 7));
                a_len = int'($urandom_range(DEB, DEB + 6)); b_len = int'($urandom_range(DEB, DEB + 6));
            end
            5: begin
                busy_len = int'($urandom_range(5, 30));
                if ($urandom_range(0, 1) == 1) begin a_en = 1; a_len = int'($urandom_range(DEB, DEB + 6)); end
                else begin b_en = 1; b_len = int'($urandom_range(DEB, DEB + 6)); end
            end
            default: begin
                a_en = 1; a_len = DEB + 1; a2_en = 1; a2_st = a_len + 2 * DEB + 6;
                busy_len = a2_st + DEB + 10 + int'($urandom_range(0, 5));
            end
        endcase

        @(negedge clk);
        k0 = cyc;
        // A press held for at least DEB samples becomes pending DEB+2 edges after its first low sample
        pa = (a_en == 1 && a_len >= DEB) ? k0 + a_st + DEB + 3 : NONE;
        pb = (b_en == 1 && b_len >= DEB) ? k0 + b_st + DEB + 3 : NONE;
        ga = NONE;
        gb = NONE;
        t  = k0 + busy_len + 1;   // first edge that samples busy low
        while ((ga == NONE && pa != NONE) || (gb == NONE && pb != NONE)) begin
            na    = (ga == NONE) ? pa : NONE;
            nb    = (gb == NONE) ? pb : NONE;
            first = (na < nb) ? na : nb;
            if (t < first + 1) t = first + 1;
            if (na <= t - 1 && (nb > t - 1 || m_prio == 0)) begin
                ga = t; m_prio = 1; push_grant(0, t);
            end else begin
                gb = t; m_prio = 0; push_grant(1, t);
            end
            t += 4;   // grant, settle, wait, idle before the next decision
        end
        if (a2_en == 1) begin
            p2 = k0 + a2_st + DEB + 3;
            if (p2 > pa && p2 <= ga) exp_desc++;
        end

        last_in = (a_st + a_len > b_st + b_len) ? a_st + a_len : b_st + b_len;
        if (a2_en == 1) last_in = a2_st + a_len;
        n = busy_len + last_in + 3 * DEB + 30;
        for (int r = 0; r < n; r++) begin
            if (r > 0) @(negedge clk);
            check("pend_a", int'(pend_a), (cyc >= pa && cyc < ga) ? 1 : 0);
            check("pend_b", int'(pend_b), (cyc >= pb && cyc < gb) ? 1 : 0);
            Ba   = !((a_en == 1 && r >= a_st && r < a_st + a_len) ||
                     (a2_en == 1 && r >= a2_st && r < a2_st + a_len));
            Bb   = !(b_en == 1 && r >= b_st && r < b_st + b_len);
            busy = (r < busy_len);
        end
        drain_check("grants_drained");
        check("descartes", int'(descartes), DESC_ON ? exp_desc : 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; Ba = 1'b1; Bb = 1'b1; busy = 1'b0; fim_jogo = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ponto_a", int'(ponto_a), 0);
        check("rst_ponto_b", int'(ponto_b), 0);
        check("rst_pend_a", int'(pend_a), 0);
        check("rst_pend_b", int'(pend_b), 0);
        check("rst_descartes", int'(descartes), 0);
        reset = 1'b0;

        run_scn(0); run_scn(2); run_scn(3); run_scn(3);
        run_scn(5); run_scn(6); run_scn(4); run_scn(1);
        for (int i = 0; i < 30; i++) run_scn(int'($urandom_range(0, 6)));

        // Game over with both requests pending
        @(negedge clk);
        busy = 1'b1; Ba = 1'b0; Bb = 1'b0;
        repeat (DEB + 1) @(negedge clk);
        Ba = 1'b1; Bb = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        check("lock_pend_a_set", int'(pend_a), 1);
        check("lock_pend_b_set", int'(pend_b), 1);
        fim_jogo = 1'b1;
        @(negedge clk);
        check("lock_pend_a_clr", int'(pend_a), 0);
        check("lock_pend_b_clr", int'(pend_b), 0);
        fim_jogo = 1'b0; busy = 1'b0;
        repeat (2 * DEB + 6) @(negedge clk);
        exp_desc += 2;   // simultaneous A and B presses while locked
        for (int r = 0; r < 3 * DEB + 20; r++) begin
            Ba = !(r < DEB + 1);
            Bb = !(r < DEB + 1);
            @(negedge clk);
            check("locked_pend_a", int'(pend_a), 0);
            check("locked_pend_b", int'(pend_b), 0);
        end
        drain_check("locked_no_grants");
        check("locked_descartes", int'(descartes), DESC_ON ? exp_desc : 0);

        // Button held through reset is reported after reset releases
        Ba = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_descartes", int'(descartes), 0);
        reset = 1'b0;
        k = cyc;
        m_prio = 0;
        exp_desc = 0;
        push_grant(0, k + DEB + 4);
        for (int r = 0; r < 3 * DEB + 20; r++) begin
            if (r == DEB + 2) Ba = 1'b1;
            @(negedge clk);
            check("held_pend_a", int'(pend_a), (cyc >= k + DEB + 3 && cyc < k + DEB + 4) ? 1 : 0);
        end
        drain_check("held_grant_drained");
        check("rst2_descartes_end", int'(descartes), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
